// File: rtl/mem_arb_pkg.sv
// Shared defaults and helpers for the register-memory port arbiter.
package mem_arb_pkg;
    localparam int MEM_AW   = 3;
    localparam int MEM_DW   = 16;
    localparam int MEM_NREQ = 2;

    function automatic int next_ptr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter; the master modport is the
// requester/memory environment, the slave modport is the arbiter itself.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NREQ = MEM_NREQ,
    parameter int AW   = MEM_AW,
    parameter int DW   = MEM_DW
) ();
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_rdata;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [DW-1:0]      mem_din;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_dout;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_waddr, mem_din, mem_addr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, mem_we, mem_waddr, mem_din, mem_addr
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set candidate scanning upward from ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter  int NREQ = 2,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] cand,
    input  logic [PW-1:0]   ptr,
    output logic            gnt_valid,
    output logic [PW-1:0]   gnt_idx
);
    always_comb begin
        int s;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        s         = 0;
        // Scan from the far end so the candidate closest to ptr is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= NREQ) s = s - NREQ;
            if (cand[s[PW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = s[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Grants one write and one read per cycle to the shared register memory with
// independent round-robin pointers; read data returns one cycle after accept.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = MEM_NREQ,
    parameter int AW   = MEM_AW,
    parameter int DW   = MEM_DW
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0][AW-1:0] addr_a;
    logic [NREQ-1:0][DW-1:0] wdata_a;
    logic [NREQ-1:0]         wr_cand, rd_cand;
    logic                    wr_gnt, rd_gnt;
    logic [PW-1:0]           wr_idx, rd_idx;
    logic [NREQ-1:0]         req_ready;

    logic [PW-1:0]           wr_ptr_d, wr_ptr_q;
    logic [PW-1:0]           rd_ptr_d, rd_ptr_q;
    logic [NREQ-1:0]         rsp_valid_d, rsp_valid_q;
    logic [NREQ-1:0][DW-1:0] rsp_rdata_d, rsp_rdata_q;

    assign addr_a  = bus.req_addr;
    assign wdata_a = bus.req_wdata;

    // No grants while reset is held, so the memory never sees a write then.
    assign wr_cand = bus.req_valid &  bus.req_we & {NREQ{~reset}};
    assign rd_cand = bus.req_valid & ~bus.req_we & {NREQ{~reset}};

    rr_pick #(.NREQ(NREQ)) u_wr_pick (
        .cand(wr_cand), .ptr(wr_ptr_q), .gnt_valid(wr_gnt), .gnt_idx(wr_idx)
    );

    rr_pick #(.NREQ(NREQ)) u_rd_pick (
        .cand(rd_cand), .ptr(rd_ptr_q), .gnt_valid(rd_gnt), .gnt_idx(rd_idx)
    );

    always_comb begin
        req_ready     = '0;
        bus.mem_we    = wr_gnt;
        bus.mem_waddr = '0;
        bus.mem_din   = '0;
        bus.mem_addr  = '0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        if (wr_gnt) begin
            req_ready[wr_idx] = 1'b1;
            bus.mem_waddr     = addr_a[wr_idx];
            bus.mem_din       = wdata_a[wr_idx];
            wr_ptr_d          = PW'(next_ptr(int'(wr_idx), NREQ));
        end
        if (rd_gnt) begin
            req_ready[rd_idx]   = 1'b1;
            bus.mem_addr        = addr_a[rd_idx];
            rd_ptr_d            = PW'(next_ptr(int'(rd_idx), NREQ));
            rsp_valid_d[rd_idx] = 1'b1;
            rsp_rdata_d[rd_idx] = bus.mem_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant/memory-side checks per cycle plus a
// response scoreboard drained by an independent monitor.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    logic [15:0] mem [8] = '{default: 16'h0000};

    mem_port_arbiter_if #(.NREQ(2), .AW(3), .DW(16)) bus ();

    mem_port_arbiter #(.NREQ(2), .AW(3), .DW(16)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.mem_dout = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_din;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.rsp_valid[i]) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected req=%0d got=%h exp=none t=%0t",
                                 i, bus.rsp_rdata[i*16 +: 16], $time);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_idx", i, e.idx);
                        check("rsp_data", {16'h0, bus.rsp_rdata[i*16 +: 16]}, {16'h0, e.data});
                    end
                end
            end
        end
    end

    // Called at posedge+1: drive one cycle of requests, check the combinational
    // side at negedge, queue any expected read response, then advance.
    task automatic cyc(input logic [1:0] v, input logic [1:0] we,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [1:0] exp_rdy, input logic [15:0] exp_rd);
        logic [1:0]  wwin, rwin;
        logic [2:0]  ea_w, ea_r;
        logic [15:0] ed_w;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
        wwin = exp_rdy & we;
        rwin = exp_rdy & ~we;
        ea_w = wwin[0] ? a0 : (wwin[1] ? a1 : 3'd0);
        ed_w = wwin[0] ? d0 : (wwin[1] ? d1 : 16'd0);
        ea_r = rwin[0] ? a0 : (rwin[1] ? a1 : 3'd0);
        @(negedge clk);
        check("req_ready", {30'h0, bus.req_ready}, {30'h0, exp_rdy});
        check("mem_we", {31'h0, bus.mem_we}, {31'h0, |wwin});
        check("mem_waddr", {29'h0, bus.mem_waddr}, {29'h0, ea_w});
        check("mem_din", {16'h0, bus.mem_din}, {16'h0, ed_w});
        check("mem_addr", {29'h0, bus.mem_addr}, {29'h0, ea_r});
        if (|rwin) sb.push_back('{idx: rwin[1] ? 1 : 0, data: exp_rd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b00, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b11;
        bus.req_addr  = {3'd2, 3'd1};
        bus.req_wdata = {16'h5555, 16'hAAAA};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", {30'h0, bus.req_ready}, 32'h0);
            check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
            check("rst_rsp_valid", {30'h0, bus.rsp_valid}, 32'h0);
            check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Write contention: alternation starting at r0.
        cyc(2'b11, 2'b11, 3'd1, 3'd2, 16'hAAAA, 16'h5555, 2'b01, 16'h0);
        cyc(2'b11, 2'b11, 3'd1, 3'd2, 16'hAAAA, 16'h5555, 2'b10, 16'h0);
        cyc(2'b11, 2'b11, 3'd1, 3'd2, 16'hAAAA, 16'h5555, 2'b01, 16'h0);
        cyc(2'b11, 2'b11, 3'd1, 3'd2, 16'hAAAA, 16'h5555, 2'b10, 16'h0);
        check("mem1", {16'h0, mem[1]}, 32'hAAAA);
        check("mem2", {16'h0, mem[2]}, 32'h5555);

        // Preload addr 5, then parallel write + read in one cycle.
        cyc(2'b01, 2'b01, 3'd5, 3'd0, 16'hBEEF, 16'h0, 2'b01, 16'h0);
        cyc(2'b11, 2'b01, 3'd3, 3'd5, 16'h1234, 16'h0, 2'b11, 16'hBEEF);

        // Read-during-write sees old contents, then the new value.
        cyc(2'b11, 2'b01, 3'd4, 3'd4, 16'hCAFE, 16'h0, 2'b11, 16'h0000);
        cyc(2'b10, 2'b00, 3'd0, 3'd4, 16'h0, 16'h0, 2'b10, 16'hCAFE);

        // Read fairness across an r1-only grant.
        cyc(2'b10, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b10, 16'h0000);
        cyc(2'b11, 2'b00, 3'd1, 3'd2, 16'h0, 16'h0, 2'b01, 16'hAAAA);
        cyc(2'b11, 2'b00, 3'd3, 3'd2, 16'h0, 16'h0, 2'b10, 16'h5555);
        cyc(2'b01, 2'b00, 3'd3, 3'd0, 16'h0, 16'h0, 2'b01, 16'h1234);
        idle(1);

        // Reset in the response cycle of a read: pulse must vanish at once.
        cyc(2'b01, 2'b00, 3'd5, 3'd0, 16'h0, 16'h0, 2'b01, 16'hBEEF);
        check("pre_rst_rsp_valid", {30'h0, bus.rsp_valid}, 32'h1);
        check("pre_rst_rsp_rdata", {16'h0, bus.rsp_rdata[15:0]}, 32'hBEEF);
        rst = 1'b1;
        #1;
        check("async_rsp_valid", {30'h0, bus.rsp_valid}, 32'h0);
        check("async_rsp_rdata", bus.rsp_rdata, 32'h0);
        sb.delete();
        bus.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Both pointers back at 0.
        cyc(2'b11, 2'b11, 3'd6, 3'd7, 16'h1111, 16'h2222, 2'b01, 16'h0);
        cyc(2'b11, 2'b00, 3'd6, 3'd7, 16'h0, 16'h0, 2'b01, 16'h1111);
        cyc(2'b10, 2'b11, 3'd0, 3'd7, 16'h0, 16'h2222, 2'b10, 16'h0);
        cyc(2'b10, 2'b00, 3'd0, 3'd7, 16'h0, 16'h0, 2'b10, 16'h2222);
        idle(2);

        check("sb_drain", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
